// File: rtl/spec_acc_readout.sv
// Readout scanner for the spectrum accumulator: background-subtracted streaming plus per-row peak.
// Optional clear-after-read of the accumulator DPRAM is built when SPEC_RO_CLEAR_EN is defined.
module spec_acc_readout #(
    parameter int DW     = 32,
    parameter int NUM_RB = 16,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [13:0]   acc_rdaddr,
    input  logic [DW-1:0] acc_rddata,
    output logic [13:0]   bg_rdaddr,
    input  logic [DW-1:0] bg_rddata,
    output logic          acc_clr_wea,
    output logic [13:0]   acc_clr_addr,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_rb,
    output logic [9:0]    out_bin,
    output logic          out_last,
    output logic          peak_valid,
    output logic [9:0]    peak_bin,
    output logic [DW-1:0] peak_val,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] rb;
        logic [9:0] bin;
        logic       last;
    } tag_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    rb_cnt;
    logic [9:0]    bin_cnt;
    logic          final_addr;
    logic          in_flight;
    tag_t          issue_tag;
    tag_t          tag_pipe [RD_LAT];
    tag_t          ret_tag;
    logic [DW-1:0] sub;
    logic [DW-1:0] run_val;
    logic [9:0]    run_bin;
    logic [DW-1:0] cand_val;
    logic [9:0]    cand_bin;

    assign final_addr = (rb_cnt == 4'(NUM_RB - 1)) && (bin_cnt == 10'd1023);

    // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)       state_nxt = ST_SCAN;
            ST_SCAN:  if (final_addr)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (!in_flight)  state_nxt = ST_DONE;
            ST_DONE:                   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Address generator; counters rearm to {0,0} whenever the FSM is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_cnt     <= '0;
            bin_cnt    <= '0;
            acc_rdaddr <= '0;
            bg_rdaddr  <= '0;
            issue_tag  <= '0;
        end else begin
            issue_tag.valid <= 1'b0;
            if (state == ST_IDLE) begin
                rb_cnt  <= '0;
                bin_cnt <= '0;
            end else if (state == ST_SCAN) begin
                acc_rdaddr <= {rb_cnt, bin_cnt};
                bg_rdaddr  <= {4'd0, bin_cnt};
                issue_tag  <= '{valid: 1'b1, rb: rb_cnt, bin: bin_cnt,
                               last: (bin_cnt == 10'd1023)};
                bin_cnt    <= bin_cnt + 10'd1;
                if (bin_cnt == 10'd1023) begin
                    rb_cnt <= rb_cnt + 4'd1;
                end
            end
        end
    end

    // Tags ride alongside the RAM read latency so they meet their data at the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        in_flight = issue_tag.valid;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight | tag_pipe[i].valid;
        end
    end

    assign ret_tag = tag_pipe[RD_LAT-1];

    // Bin 0 restarts the tracker; strict > keeps the lowest bin on ties.
    always_comb begin
        sub      = (acc_rddata > bg_rddata) ? (acc_rddata - bg_rddata) : '0;
        cand_val = run_val;
        cand_bin = run_bin;
        if (ret_tag.bin == 10'd0) begin
            cand_val = sub;
            cand_bin = '0;
        end else if (sub > run_val) begin
            cand_val = sub;
            cand_bin = ret_tag.bin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_rb     <= '0;
            out_bin    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_val   <= '0;
            run_val    <= '0;
            run_bin    <= '0;
        end else begin
            out_valid  <= ret_tag.valid;
            out_last   <= ret_tag.valid & ret_tag.last;
            peak_valid <= ret_tag.valid & ret_tag.last;
            if (ret_tag.valid) begin
                out_data <= sub;
                out_rb   <= ret_tag.rb;
                out_bin  <= ret_tag.bin;
                run_val  <= cand_val;
                run_bin  <= cand_bin;
                if (ret_tag.last) begin
                    peak_val <= cand_val;
                    peak_bin <= cand_bin;
                end
            end
        end
    end

`ifdef SPEC_RO_CLEAR_EN
    // Zero each location as its sample leaves, so the next frame starts from a clean array.
    assign acc_clr_wea  = out_valid;
    assign acc_clr_addr = {out_rb, out_bin};
`else
    assign acc_clr_wea  = 1'b0;
    assign acc_clr_addr = '0;
`endif

endmodule

// File: tb/tb_spec_acc_readout.sv
// Randomized self-checking bench for spec_acc_readout: DPRAM model with read latency,
// scoreboard of expected samples and row-peak model computed by plain argmax.
`timescale 1ns/1ps
module tb_spec_acc_readout;

    localparam int DW     = 32;
    localparam int NUM_RB = 16;
    localparam int RD_LAT = 2;
    localparam int NBIN   = 1024;
    localparam int NSAMP  = NUM_RB * NBIN;
    localparam int OUT_W  = 3*14 + 2*DW + 4 + 2*10 + 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [13:0]   acc_rdaddr;
    logic [DW-1:0] acc_rddata;
    logic [13:0]   bg_rdaddr;
    logic [DW-1:0] bg_rddata;
    logic          acc_clr_wea;
    logic [13:0]   acc_clr_addr;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_rb;
    logic [9:0]    out_bin;
    logic          out_last;
    logic          peak_valid;
    logic [9:0]    peak_bin;
    logic [DW-1:0] peak_val;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    spec_acc_readout #(.DW(DW), .NUM_RB(NUM_RB), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .acc_rdaddr   (acc_rdaddr),
        .acc_rddata   (acc_rddata),
        .bg_rdaddr    (bg_rdaddr),
        .bg_rddata    (bg_rddata),
        .acc_clr_wea  (acc_clr_wea),
        .acc_clr_addr (acc_clr_addr),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_rb       (out_rb),
        .out_bin      (out_bin),
        .out_last     (out_last),
        .peak_valid   (peak_valid),
        .peak_bin     (peak_bin),
        .peak_val     (peak_val),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // DPRAM model: contents loaded by the stimulus, clears tracked per load epoch.
    logic [DW-1:0] acc_mem  [NSAMP];
    logic [DW-1:0] bg_mem   [NBIN];
    int            clr_epoch [NSAMP];
    int            cur_epoch = 1;
    logic [DW-1:0] acc_pipe [RD_LAT];
    logic [DW-1:0] bg_pipe  [RD_LAT];

    always @(posedge clk) begin
        acc_pipe[0] <= (clr_epoch[acc_rdaddr] == cur_epoch) ? '0 : acc_mem[acc_rdaddr];
        bg_pipe[0]  <= bg_mem[bg_rdaddr[9:0]];
        for (int i = 1; i < RD_LAT; i++) begin
            acc_pipe[i] <= acc_pipe[i-1];
            bg_pipe[i]  <= bg_pipe[i-1];
        end
        if (acc_clr_wea) clr_epoch[acc_clr_addr] <= cur_epoch;
    end

    assign acc_rddata = acc_pipe[RD_LAT-1];
    assign bg_rddata  = bg_pipe[RD_LAT-1];

    // Reference model state
    bit            expect_cleared = 1'b0;
    logic [DW-1:0] pk_val [NUM_RB];
    int            pk_bin [NUM_RB];
    logic [DW-1:0] obs_data   [NSAMP];
    logic [DW-1:0] obs_pk_val [NUM_RB];
    logic [9:0]    obs_pk_bin [NUM_RB];

    function automatic logic [DW-1:0] model_out(input int n);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = expect_cleared ? '0 : acc_mem[n];
        b = bg_mem[n % NBIN];
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [OUT_W-1:0] all_outputs();
        return {acc_rdaddr, bg_rdaddr, acc_clr_wea, acc_clr_addr, out_valid, out_data,
                out_rb, out_bin, out_last, peak_valid, peak_bin, peak_val, busy, done};
    endfunction

    task automatic compute_peaks();
        logic [DW-1:0] v;
        for (int r = 0; r < NUM_RB; r++) begin
            pk_val[r] = '0;
            pk_bin[r] = 0;
            for (int b = 0; b < NBIN; b++) begin
                v = model_out(r*NBIN + b);
                if (v > pk_val[r]) begin
                    pk_val[r] = v;
                    pk_bin[r] = b;
                end
            end
        end
    endtask

    // kind 0: ramp, kind 1: clamp/peak/zero rows plus random rows, kind 2: fully random
    task automatic load_pattern(input int kind);
        int r;
        int b;
        cur_epoch++;
        expect_cleared = 1'b0;
        for (int i = 0; i < NBIN; i++) begin
            case (kind)
                0:       bg_mem[i] = '0;
                1:       bg_mem[i] = (i == 5) ? 32'd150 : 32'd40;
                default: bg_mem[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0
                                                                  : 32'($urandom_range(0, 200));
            endcase
        end
        for (int n = 0; n < NSAMP; n++) begin
            r = n / NBIN;
            b = n % NBIN;
            case (kind)
                0: acc_mem[n] = 32'(n);
                1: begin
                    if (r == 3)      acc_mem[n] = (b == 7 || b == 200) ? 32'd940 : 32'd50;
                    else if (r == 5) acc_mem[n] = '0;
                    else if (r >= 8) acc_mem[n] = 32'($urandom_range(0, 1000));
                    else             acc_mem[n] = 32'd100;
                end
                default: acc_mem[n] = ($urandom_range(0, 7) == 0) ? $urandom
                                                                   : 32'($urandom_range(0, 400));
            endcase
        end
    endtask

    // Pulses start, then scoreboards every cycle until busy falls after done.
    task automatic scan_and_check(input int restart_at);
        int n;
        int last_cyc;
        int done_seen;
        int done_cyc;
        int rb_e;
        int bin_e;
        int cyc;
        bit finished;
        bit exp_pv;
        logic [DW-1:0] exp_v;
        logic [13:0] hist_acc [$];
        logic [13:0] hist_bg  [$];
        n = 0; last_cyc = -10; done_seen = 0; done_cyc = 0; finished = 1'b0;
        compute_peaks();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!finished && cyc < NSAMP + 200) begin
            hist_acc.push_back(acc_rdaddr);
            hist_bg.push_back(bg_rdaddr);
            exp_pv = (out_valid === 1'b1) && ((n % NBIN) == NBIN - 1);
            checks++;
            if (peak_valid !== exp_pv)
                begin errors++; $display("FAIL peak_valid cyc=%0d got=%b exp=%b", cyc, peak_valid, exp_pv); end
            if (out_valid === 1'b1) begin
                checks++;
                if (n >= NSAMP) begin
                    errors++; $display("FAIL extra_sample cyc=%0d got=%0d samples exp=%0d", cyc, n + 1, NSAMP);
                end else begin
                    rb_e = n / NBIN;
                    bin_e = n % NBIN;
                    exp_v = model_out(n);
                    if (out_rb !== 4'(rb_e) || out_bin !== 10'(bin_e))
                        begin errors++; $display("FAIL tag n=%0d got=%0d/%0d exp=%0d/%0d", n, out_rb, out_bin, rb_e, bin_e); end
                    checks++;
                    if (out_data !== exp_v)
                        begin errors++; $display("FAIL data n=%0d got=%0h exp=%0h", n, out_data, exp_v); end
                    checks++;
                    if (out_last !== (bin_e == NBIN - 1))
                        begin errors++; $display("FAIL last n=%0d got=%b exp=%b", n, out_last, bin_e == NBIN - 1); end
                    checks++;
                    if (cyc < RD_LAT + 1 || hist_acc[cyc-RD_LAT-1] !== {out_rb, out_bin}
                        || hist_bg[cyc-RD_LAT-1] !== {4'd0, out_bin})
                        begin errors++; $display("FAIL latency n=%0d cyc=%0d got_tag=%0h exp_issue=%0h", n, cyc, {out_rb, out_bin}, 14'(n)); end
                    if (n > 0) begin
                        checks++;
                        if (last_cyc != cyc - 1)
                            begin errors++; $display("FAIL gap n=%0d got_cyc=%0d exp_cyc=%0d", n, cyc, last_cyc + 1); end
                    end
                    if (exp_pv) begin
                        checks++;
                        if (peak_bin !== 10'(pk_bin[rb_e]) || peak_val !== pk_val[rb_e])
                            begin errors++; $display("FAIL peak rb=%0d got=%0d/%0h exp=%0d/%0h", rb_e, peak_bin, peak_val, pk_bin[rb_e], pk_val[rb_e]); end
                        obs_pk_bin[rb_e] = peak_bin;
                        obs_pk_val[rb_e] = peak_val;
                    end
`ifdef SPEC_RO_CLEAR_EN
                    checks++;
                    if (acc_clr_wea !== 1'b1 || acc_clr_addr !== 14'(n))
                        begin errors++; $display("FAIL clear n=%0d got=%b/%0h exp=1/%0h", n, acc_clr_wea, acc_clr_addr, 14'(n)); end
`endif
                    obs_data[n] = out_data;
                end
                n++;
                last_cyc = cyc;
            end
`ifdef SPEC_RO_CLEAR_EN
            else begin
                checks++;
                if (acc_clr_wea !== 1'b0)
                    begin errors++; $display("FAIL clear_idle cyc=%0d got=%b exp=0", cyc, acc_clr_wea); end
            end
`else
            checks++;
            if (acc_clr_wea !== 1'b0 || acc_clr_addr !== 14'd0)
                begin errors++; $display("FAIL clear_off cyc=%0d got=%b/%0h exp=0/0", cyc, acc_clr_wea, acc_clr_addr); end
`endif
            if (done === 1'b1) begin
                done_seen++;
                checks++;
                if (done_seen == 1) begin
                    done_cyc = cyc;
                    if (n != NSAMP || cyc != last_cyc + 1)
                        begin errors++; $display("FAIL done_timing got_cyc=%0d samples=%0d exp_cyc=%0d samples=%0d", cyc, n, last_cyc + 1, NSAMP); end
                end else begin
                    errors++; $display("FAIL done_pulses got=%0d exp=1", done_seen);
                end
            end
            if (done_seen == 0) begin
                checks++;
                if (busy !== 1'b1)
                    begin errors++; $display("FAIL busy_scan cyc=%0d got=%b exp=1", cyc, busy); end
            end else if (cyc == done_cyc + 1) begin
                checks++;
                if (busy !== 1'b0)
                    begin errors++; $display("FAIL busy_after_done got=%b exp=0", busy); end
                finished = 1'b1;
            end
            start = (cyc == restart_at) ? 1'b1 : 1'b0;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!finished)
            begin errors++; $display("FAIL scan_timeout got_samples=%0d exp=%0d", n, NSAMP); end
        checks++;
        if (n != NSAMP)
            begin errors++; $display("FAIL sample_count got=%0d exp=%0d", n, NSAMP); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL idle_after got=%b%b%b exp=000", out_valid, done, busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outputs() !== '0)
            begin errors++; $display("FAIL reset_outputs got=%0h exp=0", all_outputs()); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL idle_after_reset got=%b%b exp=00", busy, out_valid); end
    endtask

    task automatic test_ramp();
        load_pattern(0);
        scan_and_check(-1);
        checks++;
        if (obs_pk_bin[0] !== 10'd1023 || obs_pk_val[15] !== 32'd16383)
            begin errors++; $display("FAIL ramp_peak got=%0d/%0d exp=1023/16383", obs_pk_bin[0], obs_pk_val[15]); end
    endtask

    task automatic test_clamp_and_peak();
        load_pattern(1);
        scan_and_check(-1);
        checks++;
        if (obs_data[5] !== 32'd0)
            begin errors++; $display("FAIL clamp_zero got=%0h exp=0", obs_data[5]); end
        checks++;
        if (obs_data[6] !== 32'd60)
            begin errors++; $display("FAIL clamp_diff got=%0d exp=60", obs_data[6]); end
        checks++;
        if (obs_pk_bin[3] !== 10'd7 || obs_pk_val[3] !== 32'd900)
            begin errors++; $display("FAIL peak_tie got=%0d/%0d exp=7/900", obs_pk_bin[3], obs_pk_val[3]); end
        checks++;
        if (obs_pk_bin[5] !== 10'd0 || obs_pk_val[5] !== 32'd0)
            begin errors++; $display("FAIL peak_zero_row got=%0d/%0d exp=0/0", obs_pk_bin[5], obs_pk_val[5]); end
    endtask

    task automatic test_reset_mid_scan();
        int waited;
        load_pattern(2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        waited = 0;
        while (acc_rdaddr !== {4'd4, 10'd300} && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 6000)
            begin errors++; $display("FAIL mid_scan_wait got_addr=%0h exp=%0h", acc_rdaddr, {4'd4, 10'd300}); end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== '0)
            begin errors++; $display("FAIL abort_outputs got=%0h exp=0", all_outputs()); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL abort_quiet got=%b%b%b exp=000", done, out_valid, busy); end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        load_pattern(2);
        scan_and_check(500);
    endtask

    task automatic test_clear();
`ifdef SPEC_RO_CLEAR_EN
        expect_cleared = 1'b1;
`endif
        scan_and_check(-1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_clamp_and_peak();
        test_reset_mid_scan();
        test_back_to_back();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spec_acc_readout.md
Name: spec_acc_readout

Overview:
Downstream consumer of the spectrum accumulator. On the accumulator's done pulse it scans the accumulated-spectrum DPRAM (16 range rows × 1024 Doppler bins, 14-bit address {rb[3:0], bin[9:0]}) and reads the background DPRAM at the same bin. It streams background-subtracted, zero-clamped magnitudes with range/bin tags. It reports the per-range-row peak bin and value for the detection stage.

Parameters:
DW, 32, width of accumulated and background words
NUM_RB, 16, range rows scanned (1..16)
RD_LAT, 2, DPRAM read latency in clk cycles (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse (accumulator done) starting a scan
acc_rdaddr  out  14  accumulated DPRAM read address {rb, bin}
acc_rddata  in  DW  accumulated DPRAM read data, RD_LAT after address
bg_rdaddr  out  14  background DPRAM read address {4'd0, bin}
bg_rddata  in  DW  background read data, RD_LAT after address
acc_clr_wea  out  1  clear write enable (optional feature)
acc_clr_addr  out  14  clear write address (optional feature)
out_valid  out  1  output sample strobe
out_data  out  DW  max(acc - bg, 0)
out_rb  out  4  range row of out_data
out_bin  out  10  Doppler bin of out_data
out_last  out  1  high with bin 1023 of each row
peak_valid  out  1  per-row peak strobe
peak_bin  out  10  bin of row maximum
peak_val  out  DW  row maximum value
busy  out  1  high from scan start until done
done  out  1  one-cycle pulse when the scan is fully drained

Behaviour:
- Reset: every output 0; FSM IDLE; counters, pipeline valids and the peak tracker cleared. Reset mid-scan aborts immediately and drops all samples in flight.
- FSM IDLE -> SCAN on start. SCAN -> DRAIN on the cycle the final address (rb=NUM_RB-1, bin=1023) is issued. DRAIN -> DONE when the pipeline is empty. DONE -> IDLE after one cycle.
- start is ignored unless the FSM is in IDLE.
- busy = (state != IDLE). done = 1 only in DONE.
- SCAN issues one address per cycle: bin counts 0..1023 and wraps to 0 with rb+1. rb starts at 0.
- acc_rdaddr and bg_rdaddr are registered and hold their last value outside SCAN.
- Tag pipeline: a shift register of depth RD_LAT carries {valid, rb, bin, last} alongside the RAM latency.
- Output stage: registered one cycle after data returns. Address issued at cycle t produces out_valid at t+RD_LAT+1. Total out_valid count = NUM_RB*1024, contiguous with no gaps.
- Subtraction: unsigned DW-bit. If acc_rddata > bg_rddata, out_data = acc_rddata - bg_rddata; otherwise out_data = 0. No wrap.
- Peak tracker: reset to value 0, bin 0 at bin 0 of each row. It takes a new maximum only on strictly greater values, so ties keep the lowest bin. An all-zero row reports bin 0, value 0.
- Comparison includes the current sample. peak_valid is asserted in the same cycle as out_last, with that row's final peak.
- out_valid, out_last, peak_valid and done are single-cycle strobes. The out_* and peak_* data outputs hold their value between strobes.

Optional Feature:
SPEC_RO_CLEAR_EN
- Defined: clear-after-read. For every sample reaching the output stage, acc_clr_wea=1 and acc_clr_addr={out_rb, out_bin} in the same cycle, writing zero to that DPRAM location through the write port. The write data is tied to 0 by the integrating top level. The accumulator DPRAM is therefore zeroed for the next frame by the time done fires.
- Undefined: acc_clr_wea and acc_clr_addr are held at 0 and no clear logic is synthesised.

Test Plan:
- Reset then start, RAM model acc=(rb<<10)+bin, bg=0, NUM_RB=16, RD_LAT=2 -> first out_valid 3 cycles after first address; 16384 contiguous samples with out_data equal to the address; out_last at each bin 1023; done exactly 1 cycle after the last sample; busy low the cycle after done.
- acc=100 everywhere, bg=150 for bin 5 and 40 elsewhere -> out_data=0 at bin 5 and 60 elsewhere; no wrap to a large value.
- Row 3 with acc=900 at bins 7 and 200, 10 elsewhere, bg=0 -> peak_valid for rb 3 with peak_bin=7, peak_val=900 (tie keeps lowest bin).
- start re-pulsed at scan cycle 500 -> ignored; sample count stays 16384; single done pulse.
- rst asserted mid-SCAN at rb=4, bin=300 -> all outputs 0 next edge, no done; a new start after release gives a full clean scan from {0,0}.
- With SPEC_RO_CLEAR_EN defined -> acc_clr_wea pulses 16384 times, each with acc_clr_addr equal to {out_rb, out_bin}; a second scan reads all zeros. With it undefined, acc_clr_wea stays 0.
